// File: rtl/fetch_pc_unit_pkg.sv
// Shared definitions for the fetch stage: fetch state, default parameters,
// the NOP encoding and the byte-to-word address helper.
package fetch_pc_unit_pkg;

    localparam logic [31:0] DEFAULT_RESET_PC   = 32'h0000_0000;
    localparam int unsigned DEFAULT_IMEM_DEPTH = 1024;
    localparam logic [31:0] DEFAULT_NOP_INSTR  = 32'h0000_0013;  // addi x0,x0,0

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FAULT = 1'b1
    } fetch_state_e;

    function automatic logic [31:0] byte_to_word(input logic [31:0] byte_addr);
        return {2'b00, byte_addr[31:2]};
    endfunction

endpackage

// File: rtl/fetch_pc_unit.sv
// Program counter and fetch control ahead of a registered-read instruction
// memory: stall re-read, zero-bubble redirect, NOP gating and sticky fault.
module fetch_pc_unit
    import fetch_pc_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
    parameter int unsigned IMEM_DEPTH = DEFAULT_IMEM_DEPTH,
    parameter logic [31:0] NOP_INSTR  = DEFAULT_NOP_INSTR
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic [31:0] instr_i,
    output logic [31:0] PC_out_address,
    output logic [31:0] instr_o,
    output logic        instr_valid,
    output logic [31:0] instr_pc,
    output logic [31:0] instr_pc_plus4,
    output logic        fault,
    output logic [31:0] fault_pc
);

    localparam logic [31:0] DEPTH_WORDS = 32'(IMEM_DEPTH);

    logic [31:0]  pc_q;
    logic [31:0]  ipc_q;
    logic         valid_q;
    fetch_state_e state_q;
    logic [31:0]  fault_pc_q;

    logic [31:0]  fa;
    logic         fa_bad;

    // The memory has no read enable, so a stall re-presents the held word's address.
    function automatic logic [31:0] next_fetch_addr(
        input logic        stall_in,
        input logic        redirect_in,
        input logic [31:0] target,
        input logic [31:0] seq_pc,
        input logic [31:0] held_pc
    );
        if (stall_in) begin
            return held_pc;
        end else if (redirect_in) begin
            return target & ~32'd1;
        end else begin
            return seq_pc;
        end
    endfunction

    always_comb begin
        fa = fault_pc_q;
        if (state_q == ST_RUN) begin
            fa = next_fetch_addr(stall, redirect, redirect_pc, pc_q, ipc_q);
        end
    end

    assign fa_bad = fa[1] || (byte_to_word(fa) >= DEPTH_WORDS);

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q       <= RESET_PC;
            ipc_q      <= RESET_PC;
            valid_q    <= 1'b0;
            state_q    <= ST_RUN;
            fault_pc_q <= 32'd0;
        end else if (state_q == ST_RUN && !stall) begin
            if (fa_bad) begin
                state_q    <= ST_FAULT;
                fault_pc_q <= fa;
                valid_q    <= 1'b0;
            end else begin
                ipc_q   <= fa;
                pc_q    <= fa + 32'd4;
                valid_q <= 1'b1;
            end
        end
    end

    assign PC_out_address = byte_to_word(fa);
    assign instr_valid    = valid_q && (state_q == ST_RUN);
    assign instr_o        = instr_valid ? instr_i : NOP_INSTR;
    assign instr_pc       = ipc_q;
    assign instr_pc_plus4 = ipc_q + 32'd4;
    assign fault          = (state_q == ST_FAULT);
    assign fault_pc       = fault_pc_q;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed bench for fetch_pc_unit with a registered-read instruction memory model.
module tb_fetch_pc_unit;

    localparam int unsigned DEPTH = 1024;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] instr_i;
    logic [31:0] PC_out_address;
    logic [31:0] instr_o;
    logic        instr_valid;
    logic [31:0] instr_pc;
    logic [31:0] instr_pc_plus4;
    logic        fault;
    logic [31:0] fault_pc;

    logic [31:0] mem [0:DEPTH-1];
    int total;
    int bad;

    fetch_pc_unit #(
        .RESET_PC  (32'h0000_0000),
        .IMEM_DEPTH(DEPTH),
        .NOP_INSTR (NOP)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .redirect      (redirect),
        .redirect_pc   (redirect_pc),
        .instr_i       (instr_i),
        .PC_out_address(PC_out_address),
        .instr_o       (instr_o),
        .instr_valid   (instr_valid),
        .instr_pc      (instr_pc),
        .instr_pc_plus4(instr_pc_plus4),
        .fault         (fault),
        .fault_pc      (fault_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (PC_out_address < DEPTH) instr_i <= mem[PC_out_address[9:0]];
        else                        instr_i <= 32'hDEAD_BEEF;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%08h want=%08h", tag, got, exp);
        end else begin
            $display("ok   %s: %08h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic [31:0] pa, input logic v,
                           input logic [31:0] ipc, input logic [31:0] ins);
        chk({tag, ".addr"},  PC_out_address, pa);
        chk({tag, ".valid"}, {31'd0, instr_valid}, {31'd0, v});
        chk({tag, ".pc"},    instr_pc, ipc);
        chk({tag, ".instr"}, instr_o, ins);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    // Expected values for the first four free-running cycles after reset
    logic [31:0] exp_pa  [4] = '{32'd0, 32'd1, 32'd2, 32'd3};
    logic        exp_v   [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
    logic [31:0] exp_ipc [4] = '{32'd0, 32'd0, 32'd4, 32'd8};
    logic [31:0] exp_ins [4] = '{32'h13, 32'h11, 32'h22, 32'h33};

    initial begin
        total = 0;
        bad   = 0;
        for (int i = 0; i < DEPTH; i++) mem[i] = 32'hA000_0000 + i;
        mem[0]  = 32'h11;
        mem[1]  = 32'h22;
        mem[2]  = 32'h33;
        mem[3]  = 32'h44;
        mem[16] = 32'hAB;
        rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'd0;
        tick();
        do_reset();

        // Reset state and sequential fetch
        chk("rst.fault",    {31'd0, fault}, 32'd0);
        chk("rst.fault_pc", fault_pc, 32'd0);
        chk("rst.plus4",    instr_pc_plus4, 32'd4);
        for (int c = 0; c < 4; c++) begin
            chk_out($sformatf("seq%0d", c), exp_pa[c], exp_v[c], exp_ipc[c], exp_ins[c]);
            if (c < 3) tick();
        end

        // Stall for three cycles while instr_pc = 8
        stall = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk_out($sformatf("stall%0d", c), 32'd2, 1'b1, 32'd8, 32'h33);
            tick();
        end
        stall = 1'b0;
        #1;
        chk_out("unstall", 32'd3, 1'b1, 32'd8, 32'h33);
        tick();
        chk_out("after_stall", 32'd4, 1'b1, 32'd12, 32'h44);

        // Zero-bubble redirect
        redirect = 1'b1; redirect_pc = 32'h40;
        #1;
        chk("redir.addr", PC_out_address, 32'd16);
        tick();
        redirect = 1'b0;
        #1;
        chk_out("redir_tgt", 32'd17, 1'b1, 32'h40, 32'hAB);
        chk("redir.plus4", instr_pc_plus4, 32'h44);

        // jalr with bit0 set is not a fault
        redirect = 1'b1; redirect_pc = 32'h41;
        #1;
        chk("jalr.addr", PC_out_address, 32'd16);
        tick();
        redirect_pc = 32'h42;
        #1;
        chk("jalr.fault", {31'd0, fault}, 32'd0);
        chk_out("jalr_tgt", 32'd16, 1'b1, 32'h40, 32'hAB);
        tick();
        redirect = 1'b0;
        #1;
        chk("mis.fault",    {31'd0, fault}, 32'd1);
        chk("mis.fault_pc", fault_pc, 32'h42);
        chk("mis.valid",    {31'd0, instr_valid}, 32'd0);
        chk("mis.instr",    instr_o, NOP);
        chk("mis.addr",     PC_out_address, 32'd16);
        redirect = 1'b1; redirect_pc = 32'h80;
        tick();
        tick();
        redirect = 1'b0;
        #1;
        chk("mis.sticky",    {31'd0, fault}, 32'd1);
        chk("mis.sticky_pc", fault_pc, 32'h42);
        chk("mis.sticky_ad", PC_out_address, 32'd16);
        do_reset();
        chk("mis.rst_fault", {31'd0, fault}, 32'd0);
        chk_out("mis_rst", 32'd0, 1'b0, 32'd0, NOP);

        // Sequential fetch running off the end of memory
        redirect = 1'b1; redirect_pc = 32'hFF8;
        #1;
        chk("end.addr0", PC_out_address, 32'd1022);
        tick();
        redirect = 1'b0;
        #1;
        chk_out("end1", 32'd1023, 1'b1, 32'hFF8, 32'hA000_03FE);
        tick();
        chk_out("end2", 32'd1024, 1'b1, 32'hFFC, 32'hA000_03FF);
        tick();
        chk("end.fault",    {31'd0, fault}, 32'd1);
        chk("end.fault_pc", fault_pc, 32'h1000);
        chk("end.instr",    instr_o, NOP);
        chk("end.valid",    {31'd0, instr_valid}, 32'd0);
        redirect = 1'b1; redirect_pc = 32'h100;
        #1;
        chk("end.redir_addr", PC_out_address, 32'd1024);
        tick();
        redirect = 1'b0;
        chk("end.redir_fault", {31'd0, fault}, 32'd1);
        do_reset();
        chk("end.rst_fault", {31'd0, fault}, 32'd0);
        chk_out("end_rst", 32'd0, 1'b0, 32'd0, NOP);

        // Redirect held across a stall, then mid-stream reset
        tick();
        chk_out("sr0", 32'd1, 1'b1, 32'd0, 32'h11);
        stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h40;
        #1;
        chk("sr.stall0", PC_out_address, 32'd0);
        tick();
        chk_out("sr_stall1", 32'd0, 1'b1, 32'd0, 32'h11);
        tick();
        stall = 1'b0;
        #1;
        chk_out("sr_release", 32'd16, 1'b1, 32'd0, 32'h11);
        tick();
        redirect = 1'b0;
        #1;
        chk_out("sr_tgt", 32'd17, 1'b1, 32'h40, 32'hAB);
        tick();
        chk_out("sr_next", 32'd18, 1'b1, 32'h44, 32'hA000_0011);
        do_reset();
        chk_out("midrst", 32'd0, 1'b0, 32'd0, NOP);
        tick();
        chk_out("midrst1", 32'd1, 1'b1, 32'd0, 32'h11);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/fetch_pc_unit.md
Name: fetch_pc_unit

Overview:
- Program-counter and fetch-control stage directly upstream of the instruction memory.
- Holds the architectural PC and drives the memory word address. The memory has a registered read, so this block tracks the 1-cycle read latency.
- Handles stalls by re-reading the held word and handles branch/jump redirects with no bubble.
- Gates the returned word with a valid flag, substituting a NOP when the word is invalid, and raises a sticky fault on misaligned or out-of-range fetches.

Parameters:
- RESET_PC, 32'h0000_0000, byte address of the first fetch after reset; must be word-aligned.
- IMEM_DEPTH, 1024, instruction memory depth in 32-bit words.
- NOP_INSTR, 32'h0000_0013, word driven on instr_o when no valid instruction is present (addi x0,x0,0).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- stall  in  1  downstream not consuming; hold the current instruction.
- redirect  in  1  taken branch/jump from execute.
- redirect_pc  in  32  byte target address of the redirect.
- instr_i  in  32  registered read data from the instruction memory.
- PC_out_address  out  32  word index to the instruction memory (zero-extended).
- instr_o  out  32  instruction to decode: instr_i when instr_valid, else NOP_INSTR.
- instr_valid  out  1  instr_o is a real, non-squashed instruction.
- instr_pc  out  32  byte PC of instr_o.
- instr_pc_plus4  out  32  instr_pc + 4, used as the link value.
- fault  out  1  sticky fetch fault.
- fault_pc  out  32  byte address that caused the fault.

Behaviour:

Registers:
- pc_q: next byte PC to fetch.
- ipc_q: PC of the word on instr_i.
- valid_q.
- state_q: RUN or FAULT.
- fault_pc_q.

Reset (rst=1 at an edge):
- pc_q=RESET_PC, ipc_q=RESET_PC, valid_q=0, state=RUN, fault=0, fault_pc=0.
- Outputs in the first cycle after reset: instr_o=NOP_INSTR, instr_valid=0, instr_pc=RESET_PC.
- Reset mid-operation discards any in-flight word; the next fetch is RESET_PC.

Fetch address (combinational) in RUN, priority order:
- stall=1: fa=ipc_q, so the memory re-reads the held word because it has no enable.
- else redirect=1: fa={redirect_pc[31:1],1'b0}, i.e. bit0 is cleared.
- else: fa=pc_q.
- PC_out_address = {2'b00, fa[31:2]}.

Edge update in RUN:
- stall=1: ipc_q, valid_q, pc_q hold. redirect is ignored; execute holds it until stall drops.
- If fa[1]=1 (misaligned) or fa[31:2] >= IMEM_DEPTH: state<=FAULT, fault_pc<=fa, valid_q<=0.
- Otherwise: ipc_q<=fa, pc_q<=fa+4, valid_q<=1.

Latency and redirect:
- Address presented in cycle n gives its instruction on instr_o in cycle n+1.
- A redirect in cycle n gives the target instruction in n+1, with zero bubbles and no squash needed.
- Sequential PC increment wraps mod 2^32; in practice the range check faults first.

FAULT state:
- fault=1, instr_valid=0, instr_o=NOP_INSTR.
- PC_out_address = {2'b00, fault_pc_q[31:2]}.
- stall and redirect are ignored; the only exit is rst.

Output rules:
- instr_pc=ipc_q; instr_pc_plus4=ipc_q+4; fault=(state_q==FAULT).
- All outputs depend only on registers, except:
  - PC_out_address is combinational from stall, redirect and redirect_pc.
  - instr_o muxes instr_i.

Decomposition:
- Shared package holds:
  - NOP_INSTR constant.
  - fetch state enum {RUN, FAULT}.
  - byte-to-word address helper.
  - RESET_PC default.
  - IMEM_DEPTH default, shared with the memory.
- Single module; no sub-module is needed. The next-fetch-address mux may be a local function.

Test Plan:
- Reset then 4 free-running cycles, memory holding 0x11,0x22,0x33,0x44 at words 0..3 -> PC_out_address 0,1,2,3; instr_valid 0,1,1,1; instr_pc 0,0,4,8; instr_o NOP_INSTR,0x11,0x22,0x33.
- stall=1 for 3 cycles while instr_pc=8 -> PC_out_address=2 each cycle; instr_o=0x33 and instr_pc=8 held; after release, instr_pc=12 and instr_o=0x44.
- redirect=1, redirect_pc=0x40 (word 16 holds 0xAB) -> PC_out_address=16 that cycle; next cycle instr_pc=0x40, instr_o=0xAB; then PC_out_address=17.
- redirect_pc=0x41 (jalr bit0) -> fetch at word 16 with no fault; redirect_pc=0x42 -> fault=1, fault_pc=0x42, instr_valid=0, and the block stays faulted until rst.
- Sequential fetch reaching byte 4*IMEM_DEPTH=0x1000 -> fault=1, fault_pc=0x1000, instr_o=NOP_INSTR; redirect then has no effect; rst restores RESET_PC.
- stall=1 and redirect=1 together for 2 cycles, then stall=0 -> no redirect while stalled; redirect honoured in the first unstalled cycle; rst asserted mid-stream -> instr_valid=0 next cycle and fetch restarts at word 0.
